// File: rtl/pong_pkg.sv
// Shared constants, state type and clamp helper for the paddle motion datapath.
package pong_pkg;

   localparam int SCREEN_H = 480;
   localparam int PADDLE_H = 80;
   localparam int Y_W      = 10;
   localparam int NUM_CH   = 2;
   localparam int SPD_W    = 4;
   localparam int CNT_W    = 3;

   localparam logic [SPD_W-1:0] SPEED_MIN   = SPD_W'(2);
   localparam logic [SPD_W-1:0] SPEED_MAX   = SPD_W'(8);
   localparam logic [CNT_W-1:0] RAMP_FRAMES = CNT_W'(4);

   localparam logic [Y_W-1:0] Y_MAX    = Y_W'(SCREEN_H - PADDLE_H);
   localparam logic [Y_W-1:0] Y_CENTER = Y_W'((SCREEN_H - PADDLE_H) / 2);

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      CRUISE
   } paddle_state_t;

   // Saturate a signed candidate position into [0, Y_MAX].
   function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W:0] v);
      logic [Y_W-1:0] r;
      if (v < 0)
         r = '0;
      else if (v > $signed({1'b0, Y_MAX}))
         r = Y_MAX;
      else
         r = v[Y_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/paddle_motion_controller_if.sv
// Button/tick inputs and paddle position outputs bundled for the motion controller.
interface paddle_motion_controller_if;
   import pong_pkg::*;

   logic                           frame_tick;
   logic                           center_req;
   logic [NUM_CH-1:0]              btn_up;
   logic [NUM_CH-1:0]              btn_down;
   logic [Y_W-1:0]                 paddle_y_l;
   logic [Y_W-1:0]                 paddle_y_r;
   logic [NUM_CH-1:0]              paddle_moving;

   modport master (
      output frame_tick, center_req, btn_up, btn_down,
      input  paddle_y_l, paddle_y_r, paddle_moving
   );

   modport slave (
      input  frame_tick, center_req, btn_up, btn_down,
      output paddle_y_l, paddle_y_r, paddle_moving
   );

endinterface

// File: rtl/paddle_axis.sv
// One paddle channel: direction decode, speed ramp FSM and clamped Y update per frame tick.
module paddle_axis
   import pong_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           tick_i,
   input  logic           center_i,
   input  logic           up_i,
   input  logic           down_i,
   output logic [Y_W-1:0] y_o,
   output logic           moving_o
);

   paddle_state_t      st_q, st_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [SPD_W-1:0]   spd_q, spd_d, step;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               dir_up_q, dir_up_d;
   logic               moving_q;
   logic               want, want_up, move_en;
   logic signed [Y_W:0] y_s, step_s, sum_s;

   // Both or neither pressed cancels out to "no direction".
   assign want    = up_i ^ down_i;
   assign want_up = up_i & ~down_i;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign y_s     = signed'({1'b0, y_q});

   always_comb begin
      st_d     = st_q;
      y_d      = y_q;
      spd_d    = spd_q;
      cnt_d    = cnt_q;
      dir_up_d = dir_up_q;
      move_en  = 1'b0;
      step     = SPEED_MIN;
      step_s   = '0;
      sum_s    = '0;
      if (center_i) begin
         y_d   = Y_CENTER;
         st_d  = IDLE;
         spd_d = SPEED_MIN;
         cnt_d = '0;
      end else if (tick_i) begin
         if (!want) begin
            st_d  = IDLE;
            spd_d = SPEED_MIN;
            cnt_d = '0;
         end else if (st_q == IDLE || want_up != dir_up_q) begin
            // Fresh start or reversal: restart the ramp from the slowest speed.
            move_en  = 1'b1;
            step     = SPEED_MIN;
            st_d     = RAMP;
            spd_d    = SPEED_MIN;
            cnt_d    = CNT_W'(1);
            dir_up_d = want_up;
         end else if (st_q == CRUISE) begin
            move_en = 1'b1;
            step    = SPEED_MAX;
         end else begin
            move_en = 1'b1;
            step    = spd_q;
            if (cnt_inc == RAMP_FRAMES) begin
               cnt_d = '0;
               spd_d = spd_q + SPD_W'(1);
               if (spd_d == SPEED_MAX)
                  st_d = CRUISE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         step_s = signed'({{(Y_W+1-SPD_W){1'b0}}, step});
         sum_s  = dir_up_d ? (y_s - step_s) : (y_s + step_s);
         if (move_en)
            y_d = clamp_y(sum_s);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= IDLE;
         y_q      <= Y_CENTER;
         spd_q    <= SPEED_MIN;
         cnt_q    <= '0;
         dir_up_q <= 1'b0;
         moving_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         y_q      <= y_d;
         spd_q    <= spd_d;
         cnt_q    <= cnt_d;
         dir_up_q <= dir_up_d;
         moving_q <= (st_d != IDLE);
      end
   end

   assign y_o      = y_q;
   assign moving_o = moving_q;

endmodule

// File: rtl/paddle_motion_controller.sv
// Two independent paddle channels fed from shared frame tick / recentre pulses.
module paddle_motion_controller
   import pong_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   paddle_motion_controller_if.slave bus
);

   logic [NUM_CH-1:0]          up, dn, mv;
   logic [NUM_CH-1:0][Y_W-1:0] y;

   assign up = bus.btn_up;
   assign dn = bus.btn_down;

   // Index 0 is the left player, index 1 the right.
   paddle_axis u_axis [NUM_CH-1:0] (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (bus.frame_tick),
      .center_i (bus.center_req),
      .up_i     (up),
      .down_i   (dn),
      .y_o      (y),
      .moving_o (mv)
   );

   assign bus.paddle_y_l    = y[0];
   assign bus.paddle_y_r    = y[1];
   assign bus.paddle_moving = mv;

endmodule

// File: tb/tb_paddle_motion_controller.sv
// Directed bench: frame-level model of both paddles checked every cycle, plus literal anchors.
module tb_paddle_motion_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;

   paddle_motion_controller_if bus ();

   paddle_motion_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: position plus count of consecutive frames moved in the same direction.
   int m_y[2];
   int m_n[2];
   int m_dir[2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v < 0) ? 0 : ((v > 400) ? 400 : v);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_y[i] = 200; m_n[i] = 0; m_dir[i] = 0;
         end
      end else if (bus.center_req) begin
         for (int i = 0; i < 2; i++) begin
            m_y[i] = 200; m_n[i] = 0;
         end
      end else if (bus.frame_tick) begin
         for (int i = 0; i < 2; i++) begin
            int d, spd;
            d = (bus.btn_up[i] && !bus.btn_down[i]) ? -1 :
                (bus.btn_down[i] && !bus.btn_up[i]) ? 1 : 0;
            if (d == 0) begin
               m_n[i] = 0;
            end else begin
               if (m_n[i] == 0 || d != m_dir[i]) m_n[i] = 1;
               else m_n[i]++;
               m_dir[i] = d;
               spd = 2 + (m_n[i] - 1) / 4;
               if (spd > 8) spd = 8;
               m_y[i] = clampv(m_y[i] + d * spd);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("y_l", int'(bus.paddle_y_l), m_y[0]);
         chk("y_r", int'(bus.paddle_y_r), m_y[1]);
         chk("moving", int'(bus.paddle_moving), int'({m_n[1] > 0, m_n[0] > 0}));
      end
   end

   // One frame tick, then two cycles of random button noise that must be ignored.
   task automatic tick(input logic [1:0] up, input logic [1:0] dn, input logic ctr);
      @(negedge clk);
      bus.btn_up = up; bus.btn_down = dn; bus.frame_tick = 1'b1; bus.center_req = ctr;
      @(negedge clk);
      bus.frame_tick = 1'b0; bus.center_req = 1'b0;
      bus.btn_up = 2'($urandom); bus.btn_down = 2'($urandom);
      @(negedge clk);
      bus.btn_up = 2'($urandom); bus.btn_down = 2'($urandom);
   endtask

   initial begin
      int exp2[5];
      int exp_up[4];
      exp2   = '{202, 204, 206, 208, 211};
      exp_up = '{3, 1, 0, 0};
      bus.frame_tick = 1'b0; bus.center_req = 1'b0;
      bus.btn_up = 2'b00; bus.btn_down = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_y_l", int'(bus.paddle_y_l), 200);
      chk("rst_y_r", int'(bus.paddle_y_r), 200);
      chk("rst_moving", int'(bus.paddle_moving), 0);

      // Hold left down: ramp 2,3,4.. then cruise at 8 into the bottom wall.
      for (int k = 0; k < 40; k++) begin
         tick(2'b00, 2'b01, 1'b0);
         if (k < 5)   chk("ramp_y_l", int'(bus.paddle_y_l), exp2[k]);
         if (k == 7)  chk("ramp8_y_l", int'(bus.paddle_y_l), 220);
         if (k == 23) chk("ramp24_y_l", int'(bus.paddle_y_l), 308);
         if (k == 24) chk("cruise_y_l", int'(bus.paddle_y_l), 316);
      end
      chk("wall_y_l", int'(bus.paddle_y_l), 400);
      chk("wall_y_r", int'(bus.paddle_y_r), 200);
      chk("wall_moving", int'(bus.paddle_moving), 1);

      // Reversal out of cruise restarts at the minimum speed.
      tick(2'b01, 2'b00, 1'b0);
      chk("cruise_rev_y_l", int'(bus.paddle_y_l), 398);
      tick(2'b00, 2'b00, 1'b1);
      chk("ctr_y_l", int'(bus.paddle_y_l), 200);

      // Reversal after 10 down ticks.
      repeat (10) tick(2'b00, 2'b01, 1'b0);
      chk("rev_pre_y_l", int'(bus.paddle_y_l), 228);
      tick(2'b01, 2'b00, 1'b0);
      chk("rev_first_y_l", int'(bus.paddle_y_l), 226);
      repeat (4) tick(2'b01, 2'b00, 1'b0);
      chk("rev_ramp_y_l", int'(bus.paddle_y_l), 217);

      // Both buttons on one channel cancel.
      tick(2'b01, 2'b01, 1'b0);
      chk("both_y_l", int'(bus.paddle_y_l), 217);
      chk("both_moving", int'(bus.paddle_moving), 0);
      repeat (10) begin
         @(negedge clk);
         bus.btn_up = 2'($urandom); bus.btn_down = 2'($urandom);
      end
      chk("notick_y_l", int'(bus.paddle_y_l), 217);

      // Right paddle into the top wall, then position it at Y=5.
      repeat (40) tick(2'b10, 2'b00, 1'b0);
      chk("top_y_r", int'(bus.paddle_y_r), 0);
      tick(2'b00, 2'b00, 1'b0);
      repeat (5) tick(2'b00, 2'b10, 1'b0);
      chk("odd_y_r", int'(bus.paddle_y_r), 11);
      repeat (3) tick(2'b10, 2'b00, 1'b0);
      chk("five_y_r", int'(bus.paddle_y_r), 5);
      tick(2'b00, 2'b00, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(2'b10, 2'b00, 1'b0);
         chk("clamp_top_y_r", int'(bus.paddle_y_r), exp_up[k]);
         chk("clamp_top_mv1", int'(bus.paddle_moving[1]), 1);
      end
      chk("clamp_top_y_l", int'(bus.paddle_y_l), 217);

      // Recentre coincident with a tick and held buttons: no move applied.
      repeat (3) tick(2'b00, 2'b11, 1'b0);
      tick(2'b00, 2'b11, 1'b1);
      chk("ctr_tick_y_l", int'(bus.paddle_y_l), 200);
      chk("ctr_tick_y_r", int'(bus.paddle_y_r), 200);
      chk("ctr_tick_moving", int'(bus.paddle_moving), 0);

      // Asynchronous reset in the middle of a move.
      repeat (23) tick(2'b00, 2'b01, 1'b0);
      chk("mid_y_l", int'(bus.paddle_y_l), 301);
      chk("mid_moving", int'(bus.paddle_moving), 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_y_l", int'(bus.paddle_y_l), 200);
      chk("arst_y_r", int'(bus.paddle_y_r), 200);
      chk("arst_moving", int'(bus.paddle_moving), 0);
      @(negedge clk);
      rst = 1'b0;
      tick(2'b00, 2'b01, 1'b0);
      chk("post_rst_y_l", int'(bus.paddle_y_l), 202);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
